util_axis_uart_tx_arbiter: RTL and testbench
============================================

# util_axis_uart_tx_arbiter

Round-robin arbiter that shares the single AXI-Stream transmit input of one util_axis_uart instance between NUM_REQ byte-stream requesters. A grant is held for a whole packet (up to tlast) or until MAX_BURST beats have passed, so bytes from different requesters are never interleaved inside a burst on the serial line. The block sits directly in front of the UART s_axis port, in the same aclk domain.

## Interface
- NUM_REQ, 4: number of requesting slave streams, 2..16.
- DATA_BITS, 8: byte width; must match the UART data_bits.
- MAX_BURST, 16: maximum beats per grant before forced re-arbitration, 1..65535.
- aclk  in  1  clock for all logic.
- arstn  in  1  reset, asynchronous assert, active-low; synchronous release is the integrator's responsibility.
- s_axis_tdata  in  NUM_REQ*DATA_BITS  requester data; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- s_axis_tvalid  in  NUM_REQ  per-requester valid.
- s_axis_tlast  in  NUM_REQ  per-requester end-of-packet.
- s_axis_tready  out  NUM_REQ  per-requester ready.
- m_axis_tdata  out  DATA_BITS  data to the UART s_axis_tdata.
- m_axis_tvalid  out  1  valid to the UART.
- m_axis_tready  in  1  ready from the UART.
- m_axis_tid  out  clog2(NUM_REQ), minimum 1  index of the granted requester.
- busy  out  1  high while in GRANT.

## Operation
- Two-state FSM: IDLE, GRANT. Registers: state, grant_id, last_id, beat_cnt (width clog2(MAX_BURST+1)).
- IDLE: if any s_axis_tvalid is high, choose the first valid index scanning last_id+1, last_id+2, ... modulo NUM_REQ. Register it into grant_id, clear beat_cnt, and go to GRANT. With no valid requester, stay in IDLE.
- GRANT:
  - m_axis_tdata = s_axis_tdata slice[grant_id]; m_axis_tvalid = s_axis_tvalid[grant_id].
  - s_axis_tready[grant_id] = m_axis_tready. All other s_axis_tready bits are 0.
  - m_axis_tid = grant_id; busy = 1.
  - A beat transfers when m_axis_tvalid and m_axis_tready are both high. Each transfer increments beat_cnt.
  - Release on a transfer that has s_axis_tlast[grant_id]=1, or on the transfer that makes beat_cnt equal MAX_BURST. On release: last_id <= grant_id and state goes to IDLE.
  - If the granted requester drops tvalid mid-packet, the grant is held and no other requester is served. There is no timeout.
- IDLE outputs: m_axis_tvalid=0, all s_axis_tready=0, busy=0, m_axis_tid holds the last grant_id.
- m_axis_tdata is a pure combinational mux of the registered grant_id and carries no registered data. Outputs never depend combinationally on s_axis_tvalid of a non-granted requester.

## Timing
- Reset (arstn low, takes effect immediately): state=IDLE, grant_id=0, last_id=NUM_REQ-1 (so requester 0 has first priority), beat_cnt=0. Outputs: m_axis_tvalid=0, s_axis_tready=0, m_axis_tid=0, busy=0.
- Arbitration latency: tvalid seen in IDLE at edge N gives GRANT and m_axis_tvalid at edge N+1. The first transfer is possible in the cycle after edge N+1.
- Inter-grant gap: exactly one IDLE cycle after every release, even when another requester is already waiting.
- Sustained throughput within a grant: one beat per cycle while m_axis_tready is high.
- Release and requests arriving together: arbitration happens in the following IDLE cycle using last_id already updated. The just-released requester has the lowest priority.
- MAX_BURST=1: every beat is followed by re-arbitration.
- Reset mid-packet: the grant is dropped and all readies deassert immediately. The UART may receive a truncated packet, and this is acceptable.
- A value presented on m_axis must stay stable while tvalid is high and tready is low. Stability comes from the AXIS rules on the source side, because the grant does not change inside GRANT.

## Test plan
- Single requester: NUM_REQ=4, requester 2 sends 0x41,0x42,0x43 with tlast on 0x43, m_axis_tready=1. Expected: m_axis carries 41,42,43 with tid=2; tvalid rises 1 cycle after the request; busy falls after 0x43.
- Round-robin: requesters 0..3 all hold 2-beat packets continuously. Expected: grant order 0,1,2,3,0,…; exactly one idle cycle between packets; no interleaving.
- Burst cap: MAX_BURST=16, requester 1 sends a 40-beat packet with tlast only on beat 40, and requester 3 is also valid. Expected: 16 beats from 1, then a burst from 3, then beats 17..32 from 1.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet. Expected: m_axis_tdata stable while stalled, s_axis_tready[g] tracks m_axis_tready, and all 4 bytes are delivered in order.
- Reset mid-packet: assert arstn low on beat 2 of 5. Expected: same-cycle m_axis_tvalid=0 and s_axis_tready=0; after release, requester 0 is granted first when 0 and 3 are both valid.
- Loopback: arbiter feeding util_axis_uart (4 Mbaud, 50 MHz, tx tied to rx), requesters 0 and 1 each send 3-byte packets "ABC" and "xyz". Expected: UART m_axis receives A,B,C,x,y,z.

Source files
------------

// File: rtl/util_axis_uart_tx_arbiter.sv
// rtl/util_axis_uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmit stream
module util_axis_uart_tx_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_BITS = 8,
   parameter  int MAX_BURST = 16,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                         aclk,
   input  logic                         arstn,
   input  logic [NUM_REQ*DATA_BITS-1:0] s_axis_tdata,
   input  logic [NUM_REQ-1:0]           s_axis_tvalid,
   input  logic [NUM_REQ-1:0]           s_axis_tlast,
   output logic [NUM_REQ-1:0]           s_axis_tready,
   output logic [DATA_BITS-1:0]         m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [ID_W-1:0]              m_axis_tid,
   output logic                         busy
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  grant_id, grant_id_nxt;
   logic [ID_W-1:0]  last_id, last_id_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

   logic                 pick_found;
   logic [ID_W-1:0]      pick_id;
   logic                 g_valid, g_last, xfer, burst_done;
   logic [DATA_BITS-1:0] req_data [NUM_REQ];

   // Unpack the flat requester bus so the data mux is a plain array index.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_data[i] = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
   end

   assign g_valid    = s_axis_tvalid[grant_id];
   assign g_last     = s_axis_tlast[grant_id];
   assign xfer       = (state == ST_GRANT) && g_valid && m_axis_tready;
   assign burst_done = (({1'b0, beat_cnt} + 1'b1) == (CNT_W+1)'(MAX_BURST));

   // Data and tid follow the registered grant only, never a live request.
   assign m_axis_tdata = req_data[grant_id];
   assign m_axis_tid   = grant_id;

   // Rotating-priority scan: first valid requester after last_id wins.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx        = '0;
      pick_found = 1'b0;
      pick_id    = '0;
      // Walk from the farthest offset down so the nearest valid index is kept.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(last_id) + k) % NUM_REQ);
         if (s_axis_tvalid[idx]) begin
            pick_found = 1'b1;
            pick_id    = idx;
         end
      end
   end

   // Next-state and output decode; the grant is held until tlast or burst cap.
   always_comb begin
      state_nxt     = state;
      grant_id_nxt  = grant_id;
      last_id_nxt   = last_id;
      beat_cnt_nxt  = beat_cnt;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      busy          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_nxt    = ST_GRANT;
               grant_id_nxt = pick_id;
               beat_cnt_nxt = '0;
            end
         end
         ST_GRANT: begin
            busy                    = 1'b1;
            m_axis_tvalid           = g_valid;
            s_axis_tready[grant_id] = m_axis_tready;
            if (xfer) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
               if (g_last || burst_done) begin
                  state_nxt   = ST_IDLE;
                  last_id_nxt = grant_id;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State registers; last_id starts at the top index so requester 0 leads.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state    <= ST_IDLE;
         grant_id <= '0;
         last_id  <= ID_W'(NUM_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_id_nxt;
         last_id  <= last_id_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_util_axis_uart_tx_arbiter.sv
// tb/tb_util_axis_uart_tx_arbiter.sv - scoreboard bench for the UART transmit arbiter
module tb_util_axis_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DB = 8;
   localparam int MB = 16;

   typedef struct packed {
      logic          last;
      logic [DB-1:0] data;
   } beat_t;

   logic             tb_data_clk;
   logic             arstn;
   logic [NR*DB-1:0] s_tdata;
   logic [NR-1:0]    s_tvalid, s_tlast, s_tready;
   logic [DB-1:0]    m_tdata;
   logic             m_tvalid, m_tready;
   logic [1:0]       m_tid;
   logic             busy;

   util_axis_uart_tx_arbiter #(
      .NUM_REQ  (NR),
      .DATA_BITS(DB),
      .MAX_BURST(MB)
   ) dut (
      .aclk         (tb_data_clk),
      .arstn        (arstn),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tlast (s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tid   (m_tid),
      .busy         (busy)
   );

   int checks   = 0;
   int failures = 0;

   beat_t src_q [NR][$];
   beat_t exp_q [NR][$];
   logic [NR-1:0] hs = '0;
   int xfer_cnt [NR];

   int ready_mode = 0;
   int gap_mode   = 0;
   int pc         = 0;
   logic [3:0] pat = 4'b1001;

   // reference model state (packet-level view of the arbitration rules)
   bit   md_grant  = 0;
   int   md_owner  = 0;
   int   md_beats  = 0;
   int   md_served = NR - 1;
   int   md_tid    = 0;
   bit   prev_stall = 0;
   logic [DB-1:0] prev_data = '0;

   initial begin
      tb_data_clk = 1'b0;
      forever #5 tb_data_clk = ~tb_data_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic push_pkt(input int r, input int len, input int base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = DB'(base + i);
         b.last = (i == len - 1);
         src_q[r].push_back(b);
         exp_q[r].push_back(b);
      end
   endtask

   // One stimulus step: retire accepted beats, present the next ones, set sink ready.
   task automatic drive_cycle();
      @(posedge tb_data_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (hs[i]) begin
            void'(src_q[i].pop_front());
            s_tvalid[i] = 1'b0;
         end
         if (!s_tvalid[i] && src_q[i].size() > 0 &&
             (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
            s_tvalid[i]         = 1'b1;
            s_tdata[i*DB +: DB] = src_q[i][0].data;
            s_tlast[i]          = src_q[i][0].last;
         end
      end
      case (ready_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = 1'($urandom_range(0, 1));
         default: m_tready = pat[pc % 4];
      endcase
      pc++;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0
              || s_tvalid != '0 || md_grant) && n < bound) begin
         drive_cycle();
         n++;
      end
      if (n >= bound) chk(name, 32'(n), 32'(bound - 1));
   endtask

   // Monitor: compares every cycle against the packet-level model and scoreboard.
   initial begin
      beat_t e;
      int p;
      forever begin
         @(negedge tb_data_clk);
         if (!arstn) begin
            chk("rst_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_tready", 32'(s_tready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_tid", 32'(m_tid), 32'd0);
            md_grant = 0; md_served = NR - 1; md_tid = 0; md_beats = 0;
            prev_stall = 0; hs = '0;
            for (int i = 0; i < NR; i++) exp_q[i].delete();
         end else begin
            hs = s_tvalid & s_tready;
            if (md_grant) begin
               chk("grant_busy", 32'(busy), 32'd1);
               chk("grant_tid", 32'(m_tid), 32'(md_owner));
               chk("grant_ready", 32'(s_tready), 32'(m_tready) << md_owner);
               chk("grant_tvalid", 32'(m_tvalid), 32'(s_tvalid[md_owner]));
               if (prev_stall) chk("stall_data", 32'(m_tdata), 32'(prev_data));
               prev_stall = m_tvalid && !m_tready;
               prev_data  = m_tdata;
               if (s_tvalid[md_owner] && m_tready) begin
                  if (exp_q[md_owner].size() == 0) begin
                     chk("unexpected_beat", 32'(md_owner), 32'hffff_ffff);
                  end else begin
                     e = exp_q[md_owner].pop_front();
                     chk("beat_data", 32'(m_tdata), 32'(e.data));
                     xfer_cnt[md_owner]++;
                     md_beats++;
                     if (e.last || md_beats == MB) begin
                        md_grant  = 0;
                        md_served = md_owner;
                     end
                  end
               end
            end else begin
               chk("idle_busy", 32'(busy), 32'd0);
               chk("idle_tvalid", 32'(m_tvalid), 32'd0);
               chk("idle_tready", 32'(s_tready), 32'd0);
               chk("idle_tid", 32'(m_tid), 32'(md_tid));
               prev_stall = 0;
               p = rr_pick(md_served, s_tvalid);
               if (p >= 0) begin
                  md_grant = 1; md_owner = p; md_tid = p; md_beats = 0;
               end
            end
         end
      end
   end

   initial begin
      int n, start;
      arstn = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
      for (int i = 0; i < NR; i++) xfer_cnt[i] = 0;
      repeat (3) @(posedge tb_data_clk);
      #1 arstn = 1'b1;

      // single requester
      push_pkt(2, 3, 8'h41);
      wait_drain("drain_single", 100);

      // round robin with all requesters busy
      for (int rep = 0; rep < 3; rep++)
         for (int r = 0; r < NR; r++) push_pkt(r, 2, r * 16 + rep * 2);
      wait_drain("drain_rr", 200);

      // burst cap
      push_pkt(1, 40, 8'h00);
      push_pkt(3, 5, 8'h80);
      wait_drain("drain_burst", 300);

      // backpressure pattern 1,0,0,1
      ready_mode = 2; pc = 0;
      push_pkt(0, 4, 8'hc0);
      wait_drain("drain_bp", 100);

      // randomized traffic
      ready_mode = 1; gap_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0) begin
            int r;
            r = $urandom_range(0, NR - 1);
            if (src_q[r].size() < 40) push_pkt(r, $urandom_range(1, 20), $urandom_range(0, 255));
         end
         drive_cycle();
      end
      ready_mode = 0; gap_mode = 0;
      wait_drain("drain_rand", 3000);

      // reset in the middle of a 5-beat packet
      push_pkt(1, 5, 8'h50);
      start = xfer_cnt[1];
      n = 0;
      while (xfer_cnt[1] < start + 2 && n < 50) begin
         drive_cycle();
         n++;
      end
      if (n >= 50) chk("mid_wait", 32'(n), 32'd49);
      #2 arstn = 1'b0;
      #1;
      chk("async_tvalid", 32'(m_tvalid), 32'd0);
      chk("async_tready", 32'(s_tready), 32'd0);
      repeat (2) @(posedge tb_data_clk);
      #1;
      for (int i = 0; i < NR; i++) src_q[i].delete();
      s_tvalid = '0; hs = '0;
      arstn = 1'b1;
      push_pkt(3, 2, 8'he0);
      push_pkt(0, 2, 8'hd0);
      wait_drain("drain_post_rst", 100);

      for (int i = 0; i < NR; i++) chk("exp_empty", 32'(exp_q[i].size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
